alu_issue_stage: RTL

- Decode-to-execute issue stage: registered ID/EX slice that turns a 32-bit DLX instruction plus register-file read values into ALU operands A/B and the 4-bit ALU ctrl code, i.e. the producer of everything the ALU consumes.
- Also produces destination/write-enable, flags illegal opcodes and supports stall (valid/ready) and flush.
- Sits between register-file read and the execute stage; all bit vectors are big-endian numbered [0:N-1], bit 0 = MSB.

---
 rtl/alu_issue_pkg.sv | 103 ++++++++++
 rtl/alu_issue_stage_decode.sv | 104 ++++++++++
 rtl/alu_issue_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_pkg
//  Description : DLX opcode/func encodings, ALU ctrl codes and instruction
//                field positions shared by the ALU issue stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

    typedef logic [0:3] ctrl_t;

    localparam ctrl_t c_ctrl_add = 4'b0000;
    localparam ctrl_t c_ctrl_sub = 4'b0001;
    localparam ctrl_t c_ctrl_and = 4'b0010;
    localparam ctrl_t c_ctrl_or  = 4'b0100;
    localparam ctrl_t c_ctrl_xor = 4'b0110;
    localparam ctrl_t c_ctrl_sll = 4'b1000;
    localparam ctrl_t c_ctrl_srl = 4'b1010;
    localparam ctrl_t c_ctrl_sra = 4'b1110;
    localparam ctrl_t c_ctrl_seq = 4'b0011;
    localparam ctrl_t c_ctrl_sne = 4'b0101;
    localparam ctrl_t c_ctrl_slt = 4'b0111;
    localparam ctrl_t c_ctrl_sgt = 4'b1001;
    localparam ctrl_t c_ctrl_sle = 4'b1011;
    localparam ctrl_t c_ctrl_sge = 4'b1101;

    localparam int c_op_first   = 0;
    localparam int c_op_last    = 5;
    localparam int c_rs1_first  = 6;
    localparam int c_rs1_last   = 10;
    localparam int c_rdi_first  = 11;
    localparam int c_rdi_last   = 15;
    localparam int c_rdr_first  = 16;
    localparam int c_rdr_last   = 20;
    localparam int c_imm_first  = 16;
    localparam int c_imm_last   = 31;
    localparam int c_func_first = 26;
    localparam int c_func_last  = 31;

    localparam logic [0:5] c_op_rtype = 6'h00;
    localparam logic [0:5] c_op_j     = 6'h02;
    localparam logic [0:5] c_op_jal   = 6'h03;
    localparam logic [0:5] c_op_beqz  = 6'h04;
    localparam logic [0:5] c_op_bnez  = 6'h05;
    localparam logic [0:5] c_op_addi  = 6'h08;
    localparam logic [0:5] c_op_addui = 6'h09;
    localparam logic [0:5] c_op_subi  = 6'h0A;
    localparam logic [0:5] c_op_subui = 6'h0B;
    localparam logic [0:5] c_op_andi  = 6'h0C;
    localparam logic [0:5] c_op_ori   = 6'h0D;
    localparam logic [0:5] c_op_xori  = 6'h0E;
    localparam logic [0:5] c_op_lhi   = 6'h0F;
    localparam logic [0:5] c_op_jr    = 6'h12;
    localparam logic [0:5] c_op_jalr  = 6'h13;
    localparam logic [0:5] c_op_slli  = 6'h14;
    localparam logic [0:5] c_op_srli  = 6'h16;
    localparam logic [0:5] c_op_srai  = 6'h17;
    localparam logic [0:5] c_op_seqi  = 6'h18;
    localparam logic [0:5] c_op_snei  = 6'h19;
    localparam logic [0:5] c_op_slti  = 6'h1A;
    localparam logic [0:5] c_op_sgti  = 6'h1B;
    localparam logic [0:5] c_op_slei  = 6'h1C;
    localparam logic [0:5] c_op_sgei  = 6'h1D;
    localparam logic [0:5] c_op_lw    = 6'h23;
    localparam logic [0:5] c_op_sw    = 6'h2B;

    localparam logic [0:5] c_fn_sll  = 6'h04;
    localparam logic [0:5] c_fn_srl  = 6'h06;
    localparam logic [0:5] c_fn_sra  = 6'h07;
    localparam logic [0:5] c_fn_add  = 6'h20;
    localparam logic [0:5] c_fn_addu = 6'h21;
    localparam logic [0:5] c_fn_sub  = 6'h22;
    localparam logic [0:5] c_fn_subu = 6'h23;
    localparam logic [0:5] c_fn_and  = 6'h24;
    localparam logic [0:5] c_fn_or   = 6'h25;
    localparam logic [0:5] c_fn_xor  = 6'h26;
    localparam logic [0:5] c_fn_seq  = 6'h28;
    localparam logic [0:5] c_fn_sne  = 6'h29;
    localparam logic [0:5] c_fn_slt  = 6'h2A;
    localparam logic [0:5] c_fn_sgt  = 6'h2B;
    localparam logic [0:5] c_fn_sle  = 6'h2C;
    localparam logic [0:5] c_fn_sge  = 6'h2D;

    typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_HIGH} imm_sel_t;
    typedef enum logic [0:0] {OPA_RS1, OPA_ZERO} opa_sel_t;
    typedef enum logic [1:0] {OPB_RS2, OPB_IMM, OPB_ZERO} opb_sel_t;

    // Set ops share the same low-3-bit ordering in both the R-type func and I-type opcode.
    function automatic ctrl_t set_ctrl(input logic [2:0] idx);
        ctrl_t c;
        case (idx)
            3'd0:    c = c_ctrl_seq;
            3'd1:    c = c_ctrl_sne;
            3'd2:    c = c_ctrl_slt;
            3'd3:    c = c_ctrl_sgt;
            3'd4:    c = c_ctrl_sle;
            default: c = c_ctrl_sge;
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_stage_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_decode
//  Description : Combinational DLX decode into ALU ctrl, operand selects,
//                destination, write enable and illegal flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [0:31] i_instr,
    output ctrl_t       o_ctrl,
    output imm_sel_t    o_imm_sel,
    output opa_sel_t    o_opa_sel,
    output opb_sel_t    o_opb_sel,
    output logic [0:4]  o_rd,
    output logic        o_wr_en,
    output logic        o_illegal
);

    logic [0:5] w_op;
    logic [0:5] w_func;
    ctrl_t      w_ctrl;
    imm_sel_t   w_imm_sel;
    opa_sel_t   w_opa_sel;
    opb_sel_t   w_opb_sel;
    logic [0:4] w_rd;
    logic       w_wr;
    logic       w_illegal;

    assign w_op   = i_instr[c_op_first:c_op_last];
    assign w_func = i_instr[c_func_first:c_func_last];

    always_comb begin
        w_ctrl    = c_ctrl_add;
        w_imm_sel = IMM_SEXT;
        w_opa_sel = OPA_RS1;
        w_opb_sel = OPB_IMM;
        w_rd      = i_instr[c_rdi_first:c_rdi_last];
        w_wr      = 1'b1;
        w_illegal = 1'b0;

        case (w_op)
            c_op_rtype: begin
                w_opb_sel = OPB_RS2;
                w_rd      = i_instr[c_rdr_first:c_rdr_last];
                case (w_func)
                    c_fn_add, c_fn_addu: w_ctrl = c_ctrl_add;
                    c_fn_sub, c_fn_subu: w_ctrl = c_ctrl_sub;
                    c_fn_and:            w_ctrl = c_ctrl_and;
                    c_fn_or:             w_ctrl = c_ctrl_or;
                    c_fn_xor:            w_ctrl = c_ctrl_xor;
                    c_fn_sll:            w_ctrl = c_ctrl_sll;
                    c_fn_srl:            w_ctrl = c_ctrl_srl;
                    c_fn_sra:            w_ctrl = c_ctrl_sra;
                    c_fn_seq, c_fn_sne, c_fn_slt,
                    c_fn_sgt, c_fn_sle, c_fn_sge:
                                         w_ctrl = set_ctrl(w_func[3:5]);
                    // The all-zero word is the NOP, not an unknown func.
                    default:             w_illegal = (i_instr != 32'h0);
                endcase
            end
            c_op_addi, c_op_lw: ;
            c_op_addui: w_imm_sel = IMM_ZEXT;
            c_op_subi:  w_ctrl = c_ctrl_sub;
            c_op_subui: begin w_ctrl = c_ctrl_sub; w_imm_sel = IMM_ZEXT; end
            c_op_andi:  begin w_ctrl = c_ctrl_and; w_imm_sel = IMM_ZEXT; end
            c_op_ori:   begin w_ctrl = c_ctrl_or;  w_imm_sel = IMM_ZEXT; end
            c_op_xori:  begin w_ctrl = c_ctrl_xor; w_imm_sel = IMM_ZEXT; end
            c_op_slli:  begin w_ctrl = c_ctrl_sll; w_imm_sel = IMM_ZEXT; end
            c_op_srli:  begin w_ctrl = c_ctrl_srl; w_imm_sel = IMM_ZEXT; end
            c_op_srai:  begin w_ctrl = c_ctrl_sra; w_imm_sel = IMM_ZEXT; end
            c_op_seqi, c_op_snei, c_op_slti,
            c_op_sgti, c_op_slei, c_op_sgei:
                        w_ctrl = set_ctrl(w_op[3:5]);
            c_op_sw:    w_wr = 1'b0;
            c_op_lhi:   begin w_opa_sel = OPA_ZERO; w_imm_sel = IMM_HIGH; end
            c_op_j, c_op_jal, c_op_beqz, c_op_bnez, c_op_jr, c_op_jalr:
                        w_wr = 1'b0;
            default:    w_illegal = 1'b1;
        endcase

        if (w_illegal) begin
            w_ctrl    = c_ctrl_add;
            w_opa_sel = OPA_ZERO;
            w_opb_sel = OPB_ZERO;
            w_rd      = 5'd0;
            w_wr      = 1'b0;
        end
        if (w_rd == 5'd0) begin
            w_wr = 1'b0;
        end
    end

    assign o_ctrl    = w_ctrl;
    assign o_imm_sel = w_imm_sel;
    assign o_opa_sel = w_opa_sel;
    assign o_opb_sel = w_opb_sel;
    assign o_rd      = w_rd;
    assign o_wr_en   = w_wr;
    assign o_illegal = w_illegal;

endmodule
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Registered ID/EX valid/ready slice producing ALU operands,
//                ctrl code, destination and a saturating illegal counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:31]      in_instr,
    input  logic [0:31]      in_rs1_val,
    input  logic [0:31]      in_rs2_val,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:31]      out_a,
    output logic [0:31]      out_b,
    output logic [0:3]       out_ctrl,
    output logic [0:4]       out_rd,
    output logic             out_wr_en,
    output logic             out_illegal,
    output logic [0:CNT_W-1] illegal_cnt
);

    ctrl_t      w_ctrl;
    imm_sel_t   w_imm_sel;
    opa_sel_t   w_opa_sel;
    opb_sel_t   w_opb_sel;
    logic [0:4] w_rd;
    logic       w_wr_en;
    logic       w_illegal;
    logic [0:15] w_imm16;
    logic [0:31] w_imm;
    logic [0:31] w_a;
    logic [0:31] w_b;
    logic        w_capture;

    logic             r_valid;
    logic [0:31]      r_a;
    logic [0:31]      r_b;
    ctrl_t            r_ctrl;
    logic [0:4]       r_rd;
    logic             r_wr_en;
    logic             r_illegal;
    logic [0:CNT_W-1] r_cnt;

    alu_issue_decode u_decode (
        .i_instr   (in_instr),
        .o_ctrl    (w_ctrl),
        .o_imm_sel (w_imm_sel),
        .o_opa_sel (w_opa_sel),
        .o_opb_sel (w_opb_sel),
        .o_rd      (w_rd),
        .o_wr_en   (w_wr_en),
        .o_illegal (w_illegal)
    );

    assign w_imm16 = in_instr[c_imm_first:c_imm_last];

    always_comb begin
        case (w_imm_sel)
            IMM_ZEXT: w_imm = {16'h0000, w_imm16};
            IMM_HIGH: w_imm = {w_imm16, 16'h0000};
            default:  w_imm = {{16{w_imm16[0]}}, w_imm16};
        endcase
    end

    assign w_a = (w_opa_sel == OPA_ZERO) ? 32'h0 : in_rs1_val;

    always_comb begin
        case (w_opb_sel)
            OPB_RS2: w_b = in_rs2_val;
            OPB_IMM: w_b = w_imm;
            default: w_b = 32'h0;
        endcase
    end

    assign in_ready  = !r_valid || out_ready;
    assign w_capture = in_valid && in_ready;

    // Flush outranks capture, so a squashed illegal never reaches the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_ctrl    <= c_ctrl_add;
            r_rd      <= '0;
            r_wr_en   <= 1'b0;
            r_illegal <= 1'b0;
            r_cnt     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_a       <= w_a;
            r_b       <= w_b;
            r_ctrl    <= w_ctrl;
            r_rd      <= w_rd;
            r_wr_en   <= w_wr_en;
            r_illegal <= w_illegal;
            if (w_illegal && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign out_a       = r_a;
    assign out_b       = r_b;
    assign out_ctrl    = r_ctrl;
    assign out_rd      = r_rd;
    assign out_wr_en   = r_wr_en;
    assign out_illegal = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire
